// File: rtl/key_scan_scheduler_pkg.sv
// Shared types and helpers for the key scan scheduler: FSM state encoding,
// key index type and wrap-around increment.
package key_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONFIRM = 2'd2
  } scan_state_t;

  localparam int unsigned MAX_KEYS = 16;

  typedef logic [3:0] key_idx_t;

  // Advance a key index by one, wrapping to zero after n-1.
  function automatic key_idx_t next_idx(input key_idx_t idx, input logic [4:0] n);
    if ({1'b0, idx} >= (n - 5'd1)) begin
      return 4'd0;
    end else begin
      return idx + 4'd1;
    end
  endfunction

endpackage

// File: rtl/key_scan_scheduler_rr_pick.sv
// Combinational round-robin search: first set bit of i_req at or after i_start,
// wrapping past N-1. i_start must be below N.
module rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_off;
  int             w_tot;

  // Rotate the request vector so bit 0 is the start position, then priority-encode.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_rot   = w_dbl[i_start +: N];
    o_found = 1'b0;
    w_off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_off   = i;
      end else begin
        o_found = o_found;
      end
    end
    w_tot = int'(i_start) + w_off;
    if (w_tot >= N) begin
      w_tot = w_tot - N;
    end else begin
      w_tot = w_tot;
    end
    o_idx = W'(w_tot);
  end

endmodule

// File: rtl/key_scan_scheduler.sv
// Debounces NUM_KEYS active-low buttons with one shared settle timer and delivers
// confirmed presses over valid/ready. Optional macro KEY_RELEASE_EVT_EN adds release events.
module key_scan_scheduler
  import key_scan_pkg::*;
#(
  parameter int NUM_KEYS      = 3,
  parameter int SETTLE_CYCLES = 1_000_000,
  parameter int CNT_W         = 20,
  localparam int KEY_W        = $clog2(NUM_KEYS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_key_pressed,
  output logic                o_evt_valid,
  input  logic                i_evt_ready,
  output logic [KEY_W-1:0]    o_evt_key,
  output logic                o_evt_release,
  output logic                o_overflow
);

  localparam logic [NUM_KEYS-1:0] ONE_HOT0 = {{(NUM_KEYS-1){1'b0}}, 1'b1};

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_pressed;
  logic [NUM_KEYS-1:0] r_pending;
  scan_state_t         r_state;
  logic [KEY_W-1:0]    r_k;
  logic                r_target;
  logic [CNT_W-1:0]    r_cnt;
  logic [KEY_W-1:0]    r_scan_ptr;
  logic [KEY_W-1:0]    r_out_ptr;
  logic                r_evt_valid;
  logic [KEY_W-1:0]    r_evt_key;
  logic                r_overflow;

  scan_state_t         w_state_nxt;
  logic [KEY_W-1:0]    w_k_nxt;
  logic                w_target_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [KEY_W-1:0]    w_scan_ptr_nxt;
  logic                w_confirm;
  logic [NUM_KEYS-1:0] w_diff;
  logic                w_scan_found;
  logic [KEY_W-1:0]    w_scan_idx;
  logic                w_out_found;
  logic [KEY_W-1:0]    w_out_idx;
  logic [KEY_W-1:0]    w_k_inc;
  logic [KEY_W-1:0]    w_out_inc;
  logic                w_take;
  logic [NUM_KEYS-1:0] w_set;
  logic [NUM_KEYS-1:0] w_consume;
  logic                w_collide;

  // Stable level is the complement of r_pressed, so a key differs when sync2 equals pressed.
  assign w_diff    = r_sync2 ^ ~r_pressed;
  assign w_k_inc   = KEY_W'(next_idx(key_idx_t'(r_k), 5'(NUM_KEYS)));
  assign w_out_inc = KEY_W'(next_idx(key_idx_t'(w_out_idx), 5'(NUM_KEYS)));
  assign w_take    = !r_evt_valid || i_evt_ready;

  rr_pick #(.N(NUM_KEYS), .W(KEY_W)) u_scan_pick (
    .i_req   (w_diff),
    .i_start (r_scan_ptr),
    .o_found (w_scan_found),
    .o_idx   (w_scan_idx)
  );

  rr_pick #(.N(NUM_KEYS), .W(KEY_W)) u_out_pick (
    .i_req   (r_pending),
    .i_start (r_out_ptr),
    .o_found (w_out_found),
    .o_idx   (w_out_idx)
  );

  // Two-flop synchronizer; raw keys idle high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Scan FSM next-state and datapath decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_target_nxt   = r_target;
    w_cnt_nxt      = r_cnt;
    w_scan_ptr_nxt = r_scan_ptr;
    w_confirm      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_scan_found) begin
          w_k_nxt      = w_scan_idx;
          w_target_nxt = r_sync2[w_scan_idx];
          w_cnt_nxt    = '0;
          w_state_nxt  = SETTLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (r_sync2[r_k] != r_target) begin
          w_state_nxt    = IDLE;
          w_scan_ptr_nxt = w_k_inc;
        end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = CONFIRM;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      CONFIRM: begin
        w_confirm      = 1'b1;
        w_scan_ptr_nxt = w_k_inc;
        w_cnt_nxt      = '0;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Scan FSM state and settle datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_target   <= 1'b1;
      r_cnt      <= '0;
      r_scan_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_target   <= w_target_nxt;
      r_cnt      <= w_cnt_nxt;
      r_scan_ptr <= w_scan_ptr_nxt;
    end
  end

  // Debounced level, updated only on confirmation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pressed <= '0;
    end else if (w_confirm) begin
      r_pressed[r_k] <= ~r_target;
    end else begin
      r_pressed <= r_pressed;
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] r_pending_rel;
  logic                r_evt_release;

  assign w_set = w_confirm ? (ONE_HOT0 << r_k) : '0;

  // Event kind per pending key; the newest confirmation overwrites.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending_rel <= '0;
      r_evt_release <= 1'b0;
    end else begin
      r_pending_rel <= (r_pending_rel & ~w_set) | (w_set & {NUM_KEYS{r_target}});
      if (w_take && w_out_found) begin
        r_evt_release <= r_pending_rel[w_out_idx];
      end else begin
        r_evt_release <= r_evt_release;
      end
    end
  end

  assign o_evt_release = r_evt_release;
`else
  assign w_set         = (w_confirm && !r_target) ? (ONE_HOT0 << r_k) : '0;
  assign o_evt_release = 1'b0;
`endif

  assign w_consume = (w_take && w_out_found) ? (ONE_HOT0 << w_out_idx) : '0;
  // A same-edge set and consume of one key is not a collision: the new event survives.
  assign w_collide = |(w_set & r_pending & ~w_consume);

  // Pending event vector and output handshake stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending   <= '0;
      r_out_ptr   <= '0;
      r_evt_valid <= 1'b0;
      r_evt_key   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_consume) | w_set;
      if (w_collide) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_take) begin
        if (w_out_found) begin
          r_evt_valid <= 1'b1;
          r_evt_key   <= w_out_idx;
          r_out_ptr   <= w_out_inc;
        end else begin
          r_evt_valid <= 1'b0;
        end
      end else begin
        r_evt_valid <= r_evt_valid;
      end
    end
  end

  assign o_key_pressed = r_pressed;
  assign o_evt_valid   = r_evt_valid;
  assign o_evt_key     = r_evt_key;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_key_scan_scheduler.sv
// Self-checking bench for key_scan_scheduler (NUM_KEYS=3, SETTLE_CYCLES=8):
// scoreboard of expected events plus a table of single-key transitions.
module tb_key_scan_scheduler;

  localparam int NK = 3;
  localparam int SC = 8;
  localparam int CW = 4;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic          evt_ready;
  logic [NK-1:0] key_pressed;
  logic          evt_valid;
  logic [KW-1:0] evt_key;
  logic          evt_release;
  logic          overflow;

  key_scan_scheduler #(.NUM_KEYS(NK), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_key_n       (key_n),
    .o_key_pressed (key_pressed),
    .o_evt_valid   (evt_valid),
    .i_evt_ready   (evt_ready),
    .o_evt_key     (evt_key),
    .o_evt_release (evt_release),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic          rel;
  } evt_t;

  typedef struct {
    logic [NK-1:0] key_n;
    logic [NK-1:0] exp_pressed;
  } vec_t;

  evt_t sb_q[$];
  evt_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   n_delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_evt(input int k, input logic rel);
    evt_t e;
    e.key = KW'(k);
    e.rel = rel;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new key pattern and record the events it should produce (ascending key order).
  task automatic apply_keys(input logic [NK-1:0] nk);
    for (int i = 0; i < NK; i++) begin
      if (key_n[i] && !nk[i]) push_evt(i, 1'b0);
`ifdef KEY_RELEASE_EVT_EN
      if (!key_n[i] && nk[i]) push_evt(i, 1'b1);
`endif
    end
    key_n = nk;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pressed"}, 32'(key_pressed), 32'd0);
    check({tag, "_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_key"}, 32'(evt_key), 32'd0);
    check({tag, "_release"}, 32'(evt_release), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    check("sb_drained_before_reset", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  // Scoreboard consumer: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_delivered++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got key %0d release %0d, expected none", evt_key, evt_release);
      end else begin
        mon_e = sb_q.pop_front();
        check("evt_key", 32'(evt_key), 32'(mon_e.key));
        check("evt_release", 32'(evt_release), 32'(mon_e.rel));
      end
    end
  end

  vec_t vecs[9];
  int   n0;

  initial begin
    vecs[0] = '{key_n: 3'b111, exp_pressed: 3'b000};
    vecs[1] = '{key_n: 3'b011, exp_pressed: 3'b100};
    vecs[2] = '{key_n: 3'b010, exp_pressed: 3'b101};
    vecs[3] = '{key_n: 3'b000, exp_pressed: 3'b111};
    vecs[4] = '{key_n: 3'b001, exp_pressed: 3'b110};
    vecs[5] = '{key_n: 3'b011, exp_pressed: 3'b100};
    vecs[6] = '{key_n: 3'b111, exp_pressed: 3'b000};
    vecs[7] = '{key_n: 3'b110, exp_pressed: 3'b001};
    vecs[8] = '{key_n: 3'b111, exp_pressed: 3'b000};

    // Test 1: reset values and quiet idle.
    rst       = 1'b1;
    key_n     = 3'b111;
    evt_ready = 1'b0;
    tick(4);
    check_reset_outputs("t1_in_reset");
    rst = 1'b0;
    tick(1);
    check_reset_outputs("t1_after_reset");
    evt_ready = 1'b1;
    tick(100);
    check("t1_no_event", 32'(n_delivered), 32'd0);
    check("t1_valid_low", 32'(evt_valid), 32'd0);

    // Test 2: exact latency of a clean press on key 1.
    apply_keys(3'b101);
    @(posedge clk);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("t2_valid_edge11", 32'(evt_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t2_valid_edge12", 32'(evt_valid), 32'd1);
    check("t2_key", 32'(evt_key), 32'd1);
    check("t2_pressed", 32'(key_pressed), 32'b010);
    @(posedge clk);
    @(negedge clk);
    check("t2_pulse_end", 32'(evt_valid), 32'd0);
    @(posedge clk);
    #1;

    // Table of single-key transitions with the consumer always ready.
    for (int v = 0; v < 9; v++) begin
      apply_keys(vecs[v].key_n);
      tick(40);
      check($sformatf("vec%0d_pressed", v), 32'(key_pressed), 32'(vecs[v].exp_pressed));
      check($sformatf("vec%0d_drained", v), 32'(sb_q.size()), 32'd0);
    end

    // Test 3: bounce on key 0 must not produce an event.
    n0 = n_delivered;
    for (int t = 0; t < 10; t++) begin
      key_n[0] = ~key_n[0];
      tick(3);
    end
    check("t3_no_event_in_bounce", 32'(n_delivered), 32'(n0));
    check("t3_pressed_in_bounce", 32'(key_pressed), 32'd0);
    apply_keys(3'b110);
    tick(40);
    check("t3_one_event", 32'(n_delivered), 32'(n0 + 1));
    check("t3_pressed", 32'(key_pressed), 32'b001);
    apply_keys(3'b111);
    tick(40);

    // Test 4: simultaneous presses settle serially; output stalls.
    do_reset();
    evt_ready = 1'b0;
    apply_keys(3'b010);
    tick(40);
    check("t4_pressed", 32'(key_pressed), 32'b101);
    for (int t = 0; t < 5; t++) begin
      check("t4_stall_valid", 32'(evt_valid), 32'd1);
      check("t4_stall_key", 32'(evt_key), 32'd0);
      tick(1);
    end
    n0 = n_delivered;
    evt_ready = 1'b1;
    tick(10);
    check("t4_two_events", 32'(n_delivered), 32'(n0 + 2));
    check("t4_drained", 32'(sb_q.size()), 32'd0);
    apply_keys(3'b111);
    tick(40);

    // Test 5: repeated key-2 press behind a stalled key-0 event merges and flags overflow.
    do_reset();
    evt_ready = 1'b0;
    key_n = 3'b110;
    push_evt(0, 1'b0);
    tick(30);
    key_n = 3'b010;
    push_evt(2, 1'b0);
    tick(30);
    check("t5_overflow_first", 32'(overflow), 32'd0);
    check("t5_stall_key", 32'(evt_key), 32'd0);
    key_n = 3'b110;
    tick(30);
    key_n = 3'b010;
    tick(30);
    check("t5_overflow_set", 32'(overflow), 32'd1);
    n0 = n_delivered;
    evt_ready = 1'b1;
    tick(20);
    check("t5_event_count", 32'(n_delivered), 32'(n0 + 2));
    check("t5_overflow_sticky", 32'(overflow), 32'd1);
    apply_keys(3'b111);
    tick(40);

    // Test 6: reset mid-settle with key 1 held; one press after reset.
    do_reset();
    n0 = n_delivered;
    apply_keys(3'b101);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async_reset");
    tick(2);
    rst = 1'b0;
    tick(40);
    check("t6_one_event", 32'(n_delivered), 32'(n0 + 1));
    check("t6_drained", 32'(sb_q.size()), 32'd0);
    check("t6_pressed", 32'(key_pressed), 32'b010);
    check("t6_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
